// File: rtl/frequency_generator_if.sv
// Avalon-MM 8-bit control port of the frequency generator.
// The master drives address/strobes/writedata; the slave returns registered readdata.
interface frequency_generator_if;
    logic [7:0] avs_ctrl_writedata;
    logic [7:0] avs_ctrl_readdata;
    logic [3:0] avs_ctrl_address;
    logic       avs_ctrl_write;
    logic       avs_ctrl_read;

    modport master (
        output avs_ctrl_writedata,
        output avs_ctrl_address,
        output avs_ctrl_write,
        output avs_ctrl_read,
        input  avs_ctrl_readdata
    );

    modport slave (
        input  avs_ctrl_writedata,
        input  avs_ctrl_address,
        input  avs_ctrl_write,
        input  avs_ctrl_read,
        output avs_ctrl_readdata
    );
endinterface

// File: rtl/frequency_generator.sv
// Phase-accumulator square-wave source, f = FTW * f_clk / 2^32, with a burst mode that emits
// exactly BURST_N complete periods. Programmed through an 8-bit Avalon-MM register map.
module frequency_generator #(
    parameter int ACC_WIDTH   = 32,
    parameter int BURST_WIDTH = 16
) (
    input  logic                  csi_MCLK_clk,
    input  logic                  rsi_MRST_reset_n,
    frequency_generator_if.slave  avs_ctrl,
    output logic                  coe_freq_out,
    output logic                  coe_busy
);

    localparam logic [3:0] ADDR_FTW0   = 4'd0;
    localparam logic [3:0] ADDR_FTW1   = 4'd1;
    localparam logic [3:0] ADDR_FTW2   = 4'd2;
    localparam logic [3:0] ADDR_FTW3   = 4'd3;
    localparam logic [3:0] ADDR_BN0    = 4'd4;
    localparam logic [3:0] ADDR_BN1    = 4'd5;
    localparam logic [3:0] ADDR_CTRL   = 4'd6;
    localparam logic [3:0] ADDR_STATUS = 4'd7;
    localparam logic [3:0] ADDR_REM0   = 4'd8;
    localparam logic [3:0] ADDR_REM1   = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   ftw_stage_q, ftw_stage_d;
    logic [ACC_WIDTH-1:0]   ftw_active_q, ftw_active_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [BURST_WIDTH-1:0] burst_n_q, burst_n_d;
    logic [BURST_WIDTH-1:0] burst_rem_q, burst_rem_d;
    logic                   en_q, en_d;
    logic                   burst_q, burst_d;
    logic                   inv_q, inv_d;
    logic                   done_q, done_d;
    logic                   freq_out_q, freq_out_d;
    logic [7:0]             readdata_q, readdata_d;

    logic [7:0]             wdata;
    logic                   wr_ctrl;
    logic                   wr_status;
    logic                   en_eff;
    logic                   burst_eff;
    logic                   active_q;
    logic                   active_d;
    logic                   done_set;
    logic                   period_end;
    logic [ACC_WIDTH:0]     acc_sum;

    assign wdata     = avs_ctrl.avs_ctrl_writedata;
    assign wr_ctrl   = avs_ctrl.avs_ctrl_write && (avs_ctrl.avs_ctrl_address == ADDR_CTRL);
    assign wr_status = avs_ctrl.avs_ctrl_write && (avs_ctrl.avs_ctrl_address == ADDR_STATUS);

    // The FSM sees a CTRL write in the same cycle it lands, so a stop request beats a period end.
    assign en_eff    = wr_ctrl ? wdata[0] : en_q;
    assign burst_eff = wr_ctrl ? wdata[1] : burst_q;

    assign active_q  = (state_q == ST_RUN) || (state_q == ST_BURST);
    assign active_d  = (state_d == ST_RUN) || (state_d == ST_BURST);

    // The carry out of the adder is the end of one output period.
    assign acc_sum    = {1'b0, acc_q} + {1'b0, ftw_active_q};
    assign period_end = (state_q == ST_BURST) && acc_sum[ACC_WIDTH];

    // Register-map writes
    always_comb begin
        // NOTE: every _d starts from its hold value, so no path through the case can infer a latch.
        ftw_stage_d  = ftw_stage_q;
        ftw_active_d = ftw_active_q;
        burst_n_d    = burst_n_q;
        en_d         = en_q;
        burst_d      = burst_q;
        inv_d        = inv_q;
        if (avs_ctrl.avs_ctrl_write) begin
            case (avs_ctrl.avs_ctrl_address)
                ADDR_FTW0: ftw_stage_d[7:0]   = wdata;
                ADDR_FTW1: ftw_stage_d[15:8]  = wdata;
                ADDR_FTW2: ftw_stage_d[23:16] = wdata;
                ADDR_FTW3: ftw_stage_d[31:24] = wdata;
                ADDR_BN0:  burst_n_d[7:0]     = wdata;
                ADDR_BN1:  burst_n_d[15:8]    = wdata;
                ADDR_CTRL: begin
                    en_d    = wdata[0];
                    burst_d = wdata[1];
                    inv_d   = wdata[3];
                    if (wdata[2]) begin
                        ftw_active_d = ftw_stage_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state, burst countdown and done flag
    always_comb begin
        state_d     = state_q;
        burst_rem_d = burst_rem_q;
        done_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_eff) begin
                    if (!burst_eff) begin
                        state_d = ST_RUN;
                    end else if (burst_n_q != '0) begin
                        state_d     = ST_BURST;
                        burst_rem_d = burst_n_q;
                    end else begin
                        state_d  = ST_DONE;
                        done_set = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (!en_eff) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (!en_eff) begin
                    state_d = ST_IDLE;
                end else if (period_end) begin
                    burst_rem_d = burst_rem_q - BURST_WIDTH'(1);
                    if (burst_rem_q == BURST_WIDTH'(1)) begin
                        state_d  = ST_DONE;
                        done_set = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!en_eff) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        done_d = done_q;
        if ((wr_ctrl && wdata[0]) || (wr_status && wdata[1])) begin
            done_d = 1'b0;
        end
        if (done_set) begin
            done_d = 1'b1;
        end
    end

    // Accumulator keeps its phase across a commit; it only clears when the generator stops.
    always_comb begin
        acc_d      = (active_q && active_d) ? acc_sum[ACC_WIDTH-1:0] : '0;
        freq_out_d = (active_q ? acc_q[ACC_WIDTH-1] : 1'b0) ^ inv_q;
    end

    // Read mux; readdata holds between reads and is not disturbed by writes.
    always_comb begin
        readdata_d = readdata_q;
        if (avs_ctrl.avs_ctrl_read && !avs_ctrl.avs_ctrl_write) begin
            case (avs_ctrl.avs_ctrl_address)
                ADDR_FTW0:   readdata_d = ftw_stage_q[7:0];
                ADDR_FTW1:   readdata_d = ftw_stage_q[15:8];
                ADDR_FTW2:   readdata_d = ftw_stage_q[23:16];
                ADDR_FTW3:   readdata_d = ftw_stage_q[31:24];
                ADDR_BN0:    readdata_d = burst_n_q[7:0];
                ADDR_BN1:    readdata_d = burst_n_q[15:8];
                ADDR_CTRL:   readdata_d = {4'b0000, inv_q, 1'b0, burst_q, en_q};
                ADDR_STATUS: readdata_d = {6'b000000, done_q, active_q};
                ADDR_REM0:   readdata_d = burst_rem_q[7:0];
                ADDR_REM1:   readdata_d = burst_rem_q[15:8];
                default:     readdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: <= makes every flop sample pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            // NOTE: there is no RAM here, so every register, including the output flop, is reset.
            ftw_stage_q  <= '0;
            ftw_active_q <= '0;
            acc_q        <= '0;
            burst_n_q    <= '0;
            burst_rem_q  <= '0;
            en_q         <= 1'b0;
            burst_q      <= 1'b0;
            inv_q        <= 1'b0;
            done_q       <= 1'b0;
            freq_out_q   <= 1'b0;
            readdata_q   <= 8'h00;
        end else begin
            ftw_stage_q  <= ftw_stage_d;
            ftw_active_q <= ftw_active_d;
            acc_q        <= acc_d;
            burst_n_q    <= burst_n_d;
            burst_rem_q  <= burst_rem_d;
            en_q         <= en_d;
            burst_q      <= burst_d;
            inv_q        <= inv_d;
            done_q       <= done_d;
            freq_out_q   <= freq_out_d;
            readdata_q   <= readdata_d;
        end
    end

    assign coe_freq_out                = freq_out_q;
    assign coe_busy                    = active_q;
    assign avs_ctrl.avs_ctrl_readdata  = readdata_q;

endmodule

// File: tb/tb_frequency_generator.sv
// Directed bench for frequency_generator: continuous run, bursts, staged commit,
// zero-length burst, abort, and asynchronous reset mid-burst.
module tb_frequency_generator;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic freq_out;
    logic busy;
    int   n_checks = 0;
    int   n_fail   = 0;

    frequency_generator_if bus ();

    frequency_generator #(
        .ACC_WIDTH   (32),
        .BURST_WIDTH (16)
    ) dut (
        .csi_MCLK_clk     (clk),
        .rsi_MRST_reset_n (rst_n),
        .avs_ctrl         (bus),
        .coe_freq_out     (freq_out),
        .coe_busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; the DUT samples them on the following rising edge.
    task automatic bus_write(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.avs_ctrl_address   = addr;
        bus.avs_ctrl_writedata = data;
        bus.avs_ctrl_write     = 1'b1;
        @(negedge clk);
        bus.avs_ctrl_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [7:0] data);
        @(negedge clk);
        bus.avs_ctrl_address = addr;
        bus.avs_ctrl_read    = 1'b1;
        @(negedge clk);
        bus.avs_ctrl_read    = 1'b0;
        data = bus.avs_ctrl_readdata;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] addr, input logic [7:0] exp);
        logic [7:0] rd;
        bus_read(addr, rd);
        check(tag, 32'(rd), 32'(exp));
    endtask

    // Clocks between two successive rising edges of the output; -1 if none within the budget.
    task automatic measure_period(output int cycles);
        logic prev;
        int   phase;
        int   count;
        cycles = -1;
        phase  = 0;
        count  = 0;
        prev   = freq_out;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (phase == 1) count++;
            if (!prev && freq_out) begin
                if (phase == 0) begin
                    phase = 1;
                    count = 0;
                end else begin
                    cycles = count;
                    break;
                end
            end
            prev = freq_out;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int per;
        bus.avs_ctrl_address   = 4'h0;
        bus.avs_ctrl_writedata = 8'h00;
        bus.avs_ctrl_write     = 1'b0;
        bus.avs_ctrl_read      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out", 32'(freq_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", 32'(bus.avs_ctrl_readdata), 32'd0);
        rst_n = 1'b1;

        // 1: continuous run at FTW = 0x40000000 -> 0,0,1,1 repeating
        bus_write(4'd0, 8'h00);
        bus_write(4'd1, 8'h00);
        bus_write(4'd2, 8'h00);
        bus_write(4'd3, 8'h40);
        check_reg("t1_ftw3_rb", 4'd3, 8'h40);
        bus_write(4'd4, 8'h55);
        check("t1_rdata_hold_on_write", 32'(bus.avs_ctrl_readdata), 32'h40);
        check("t1_idle_busy", 32'(busy), 32'd0);
        bus_write(4'd6, 8'h05);
        check("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("t1_wave%0d", i), 32'(freq_out), 32'((i % 4) >= 2));
        end
        bus_write(4'd6, 8'h00);

        // 2: burst of 3 periods
        bus_write(4'd4, 8'h03);
        bus_write(4'd5, 8'h00);
        bus_write(4'd6, 8'h07);
        check("t2_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("t2_wave%0d", i), 32'(freq_out), 32'((i % 4) >= 2));
        end
        check("t2_busy_end", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t2_quiet%0d", i), 32'(freq_out), 32'd0);
        end
        check_reg("t2_status", 4'd7, 8'h02);
        check_reg("t2_rem_lo", 4'd8, 8'h00);
        check_reg("t2_rem_hi", 4'd9, 8'h00);
        check_reg("t2_ctrl_rb", 4'd6, 8'h03);

        // 3: staged FTW does nothing until COMMIT
        bus_write(4'd6, 8'h00);
        bus_write(4'd6, 8'h01);
        check_reg("t3_done_cleared", 4'd7, 8'h01);
        measure_period(per);
        check("t3_period_initial", 32'(per), 32'd4);
        bus_write(4'd3, 8'h80);
        measure_period(per);
        check("t3_period_staged", 32'(per), 32'd4);
        check_reg("t3_stage_rb", 4'd3, 8'h80);
        bus_write(4'd6, 8'h05);
        measure_period(per);
        measure_period(per);
        check("t3_period_commit", 32'(per), 32'd2);
        check("t3_busy", 32'(busy), 32'd1);

        // 4a: zero-length burst goes straight to done without a pulse
        bus_write(4'd6, 8'h00);
        bus_write(4'd4, 8'h00);
        bus_write(4'd6, 8'h03);
        check_reg("t4_zero_status", 4'd7, 8'h02);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t4_zero_out%0d", i), 32'(freq_out), 32'd0);
        end
        bus_write(4'd6, 8'h02);
        check_reg("t4_done_sticky", 4'd7, 8'h02);
        bus_write(4'd7, 8'h02);
        check_reg("t4_done_w1c", 4'd7, 8'h00);

        // 4b: FTW = 0 in RUN holds the output at INV
        bus_write(4'd3, 8'h00);
        bus_write(4'd6, 8'h05);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("t4_ftw0_out%0d", i), 32'(freq_out), 32'd0);
        end
        check("t4_ftw0_busy", 32'(busy), 32'd1);
        bus_write(4'd6, 8'h0D);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t4_inv_out%0d", i), 32'(freq_out), 32'd1);
        end
        bus_write(4'd6, 8'h00);
        @(negedge clk);
        check("t4_stop_out", 32'(freq_out), 32'd0);
        check("t4_stop_busy", 32'(busy), 32'd0);

        // 5: abort a 100-period burst after 10 periods
        bus_write(4'd3, 8'h40);
        bus_write(4'd4, 8'd100);
        bus_write(4'd6, 8'h07);
        repeat (40) @(negedge clk);
        bus_write(4'd6, 8'h08);
        repeat (2) @(negedge clk);
        check("t5_abort_out", 32'(freq_out), 32'd1);
        check("t5_abort_busy", 32'(busy), 32'd0);
        check_reg("t5_status", 4'd7, 8'h00);
        check_reg("t5_rem_lo", 4'd8, 8'd90);
        check_reg("t5_rem_hi", 4'd9, 8'h00);
        check_reg("t5_ctrl_rb", 4'd6, 8'h08);
        check_reg("t5_unmapped10", 4'd10, 8'h00);
        check_reg("t5_ctrl_rb2", 4'd6, 8'h08);
        check_reg("t5_unmapped15", 4'd15, 8'h00);
        check_reg("t5_ctrl_rb3", 4'd6, 8'h08);

        // 6: asynchronous reset mid-burst
        bus_write(4'd6, 8'h0F);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (freq_out) break;
            @(negedge clk);
        end
        check("t6_out_high", 32'(freq_out), 32'd1);
        check("t6_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_out", 32'(freq_out), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_rdata", 32'(bus.avs_ctrl_readdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            check_reg($sformatf("t6_reg%0d", a), 4'(a), 8'h00);
        end
        check("t6_out_after", 32'(freq_out), 32'd0);
        check("t6_busy_after", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
